alu: RTL and testbench
======================

Name: alu

Overview:
- Registered 5-bit arithmetic/logic unit.
- controlBit selects the arithmetic or logic bank; printout selects the operation within that bank.
- Produces a 32-bit result plus two compare flags, all registered.
- Sits as a leaf datapath block, driven by a controller that presents operands and an opcode every cycle.

Parameters:
- W_IN, 5, operand width (Number1, Number2).
- W_OP, 6, opcode width (printout).
- W_OUT, 32, result width (conclusion).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- controlBit  input  1  bank select: 0 = arithmetic, 1 = logic.
- Number1  input  5  operand A, unsigned.
- Number2  input  5  operand B, unsigned.
- printout  input  6  operation code within the selected bank.
- balancebit  output  1  registered flag: 1 when Number1 > Number2 (unsigned).
- equalityBit  output  1  registered flag: 1 when Number1 == Number2.
- conclusion  output  32  registered operation result.

Behaviour:
- One clock; reset is asynchronous and active-low.
- While reset is low:
  - conclusion = 0, balancebit = 0, equalityBit = 0.
  - Outputs are held at 0 for as long as reset stays low, including reset asserted mid-operation.
- First update occurs on the first rising clock edge after reset deasserts.
- Latency: exactly 1 cycle. Inputs are sampled on the rising edge; outputs reflect that sample until the next edge.
- No handshake: every edge computes a new result.
- Flags are computed every cycle independent of controlBit and printout.
- Arithmetic bank (controlBit = 0), operands zero-extended to 32 bits, two's-complement 32-bit result:
  - 0 ADD: A+B.
  - 1 SUB: A-B; a negative result is sign-extended (e.g. 4-5 = 32'hFFFF_FFFF).
  - 2 MUL: A*B, 10-bit product zero-extended.
  - 3 DIV: A/B, integer quotient; B = 0 gives 32'hFFFF_FFFF.
  - 4 MOD: A%B; B = 0 gives A.
  - 5 INC: A+1.
  - 6 DEC: A-1, sign-extended.
- Logic bank (controlBit = 1), bitwise on the 5-bit operands; results zero-extended to 32 bits unless noted:
  - 0 AND.
  - 1 OR.
  - 2 XOR.
  - 3 NAND.
  - 4 NOR.
  - 5 XNOR.
  - 6 NOT A.
  - 7 SHL: zero-extended A shifted left by B positions, truncated to 32 bits (B up to 31).
  - 8 SHR: A shifted right by B positions, logical.
- Any unlisted opcode in either bank: conclusion = 0; flags are still updated.
- No internal state beyond the output registers.

Optional Feature:
- Macro: ALU_OPCHECK_EN.
- When defined:
  - Extra output port invalidOp (1 bit, registered).
  - invalidOp = 1 for the cycle following an unlisted opcode, 0 otherwise.
  - invalidOp resets to 0.
  - DIV and MOD with B = 0 also set invalidOp.
- When undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - width constants W_IN, W_OP, W_OUT;
  - arithmetic opcode constants OP_ADD..OP_DEC;
  - logic opcode constants OP_AND..OP_SHR;
  - bank constants BANK_ARITH, BANK_LOGIC.
- One combinational sub-module, alu_core: computes the next result and flags from the operands, controlBit and printout.
- The top level alu holds only the asynchronous-reset output registers and the optional invalidOp register.

Test Plan:
- Reset held: reset = 0, clock toggling, Number1 = 5, Number2 = 4, controlBit = 0, printout = 1 -> conclusion = 0, balancebit = 0, equalityBit = 0 on every edge.
- Release reset with the same inputs (SUB) -> one edge later: conclusion = 1, balancebit = 1, equalityBit = 0.
- Arithmetic sweep:
  - A = 4, B = 5, SUB -> 32'hFFFF_FFFF, balancebit = 0.
  - A = 31, B = 31, MUL -> 961, equalityBit = 1.
  - A = 7, B = 0, DIV -> 32'hFFFF_FFFF.
  - A = 7, B = 0, MOD -> 7.
- Logic sweep with A = 5'b10110, B = 5'b01101:
  - AND -> 4.
  - OR -> 31.
  - XOR -> 27.
  - NOT A -> 9.
  - SHL A = 1, B = 31 -> 32'h8000_0000.
- Unlisted opcode: controlBit = 1, printout = 63 -> conclusion = 0; with ALU_OPCHECK_EN, invalidOp = 1 for exactly one cycle.
- Mid-operation reset: assert reset low between edges -> outputs go to 0 immediately (asynchronously) and stay 0 until the first edge after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the registered 5-bit ALU: widths, bank selects
// and opcode values for both banks, plus an opcode-legality helper.
// Optional feature macro: ALU_OPCHECK_EN (adds the invalidOp output).
package alu_pkg;

    localparam int W_IN  = 5;
    localparam int W_OP  = 6;
    localparam int W_OUT = 32;

    localparam logic BANK_ARITH = 1'b0;
    localparam logic BANK_LOGIC = 1'b1;

    localparam logic [W_OP-1:0] OP_ADD = 6'd0;
    localparam logic [W_OP-1:0] OP_SUB = 6'd1;
    localparam logic [W_OP-1:0] OP_MUL = 6'd2;
    localparam logic [W_OP-1:0] OP_DIV = 6'd3;
    localparam logic [W_OP-1:0] OP_MOD = 6'd4;
    localparam logic [W_OP-1:0] OP_INC = 6'd5;
    localparam logic [W_OP-1:0] OP_DEC = 6'd6;

    localparam logic [W_OP-1:0] OP_AND  = 6'd0;
    localparam logic [W_OP-1:0] OP_OR   = 6'd1;
    localparam logic [W_OP-1:0] OP_XOR  = 6'd2;
    localparam logic [W_OP-1:0] OP_NAND = 6'd3;
    localparam logic [W_OP-1:0] OP_NOR  = 6'd4;
    localparam logic [W_OP-1:0] OP_XNOR = 6'd5;
    localparam logic [W_OP-1:0] OP_NOT  = 6'd6;
    localparam logic [W_OP-1:0] OP_SHL  = 6'd7;
    localparam logic [W_OP-1:0] OP_SHR  = 6'd8;

    // Opcodes in each bank are contiguous from zero, so legality is a bound check.
    function automatic logic is_listed(input logic bank, input logic [W_OP-1:0] op);
        if (bank == BANK_ARITH) begin
            return (op <= OP_DEC);
        end
        return (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational datapath of the ALU: next result and compare flags from the
// current operands, bank select and opcode. No state lives here.
// Optional feature macro: ALU_OPCHECK_EN (adds the invalid_next output).
module alu_core
    import alu_pkg::*;
(
    input  logic             bank,
    input  logic [W_IN-1:0]  a,
    input  logic [W_IN-1:0]  b,
    input  logic [W_OP-1:0]  op,
    output logic [W_OUT-1:0] result,
    output logic             greater,
    output logic             equal
`ifdef ALU_OPCHECK_EN
    ,
    output logic             invalid_next
`endif
);

    logic [W_OUT-1:0] a_ext;
    logic [W_OUT-1:0] b_ext;
    logic             b_zero;

    assign a_ext  = {{(W_OUT-W_IN){1'b0}}, a};
    assign b_ext  = {{(W_OUT-W_IN){1'b0}}, b};
    assign b_zero = (b == '0);

    assign greater = (a > b);
    assign equal   = (a == b);

    // Select the bank, then the operation; anything unlisted yields zero.
    always_comb begin
        result = '0;
        if (bank == BANK_ARITH) begin
            case (op)
                OP_ADD:  result = a_ext + b_ext;
                OP_SUB:  result = a_ext - b_ext;
                OP_MUL:  result = a_ext * b_ext;
                OP_DIV:  result = b_zero ? '1 : (a_ext / b_ext);
                OP_MOD:  result = b_zero ? a_ext : (a_ext % b_ext);
                OP_INC:  result = a_ext + 32'd1;
                OP_DEC:  result = a_ext - 32'd1;
                default: result = '0;
            endcase
        end else begin
            case (op)
                OP_AND:  result = {{(W_OUT-W_IN){1'b0}}, a & b};
                OP_OR:   result = {{(W_OUT-W_IN){1'b0}}, a | b};
                OP_XOR:  result = {{(W_OUT-W_IN){1'b0}}, a ^ b};
                OP_NAND: result = {{(W_OUT-W_IN){1'b0}}, ~(a & b)};
                OP_NOR:  result = {{(W_OUT-W_IN){1'b0}}, ~(a | b)};
                OP_XNOR: result = {{(W_OUT-W_IN){1'b0}}, ~(a ^ b)};
                OP_NOT:  result = {{(W_OUT-W_IN){1'b0}}, ~a};
                OP_SHL:  result = a_ext << b;
                OP_SHR:  result = a_ext >> b;
                default: result = '0;
            endcase
        end
    end

`ifdef ALU_OPCHECK_EN
    // Divide-by-zero in DIV/MOD is flagged the same way as an unknown opcode.
    assign invalid_next = !is_listed(bank, op) ||
                          ((bank == BANK_ARITH) && b_zero &&
                           ((op == OP_DIV) || (op == OP_MOD)));
`endif

endmodule

// File: rtl/alu.sv
// Registered 5-bit ALU top level: holds only the output registers around
// alu_core. Asynchronous active-low reset clears every output.
// Optional feature macro: ALU_OPCHECK_EN (adds registered invalidOp output).
module alu
    import alu_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             controlBit,
    input  logic [W_IN-1:0]  Number1,
    input  logic [W_IN-1:0]  Number2,
    input  logic [W_OP-1:0]  printout,
    output logic             balancebit,
    output logic             equalityBit,
    output logic [W_OUT-1:0] conclusion
`ifdef ALU_OPCHECK_EN
    ,
    output logic             invalidOp
`endif
);

    logic [W_OUT-1:0] result_next;
    logic             greater_next;
    logic             equal_next;

`ifdef ALU_OPCHECK_EN
    logic             invalid_next;
`endif

    alu_core u_core (
        .bank         (controlBit),
        .a            (Number1),
        .b            (Number2),
        .op           (printout),
        .result       (result_next),
        .greater      (greater_next),
        .equal        (equal_next)
`ifdef ALU_OPCHECK_EN
        ,
        .invalid_next (invalid_next)
`endif
    );

    // Capture a fresh result and flags on every edge; reset forces zeros.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conclusion  <= '0;
            balancebit  <= 1'b0;
            equalityBit <= 1'b0;
        end else begin
            conclusion  <= result_next;
            balancebit  <= greater_next;
            equalityBit <= equal_next;
        end
    end

`ifdef ALU_OPCHECK_EN
    // One-cycle marker for an illegal opcode or a DIV/MOD by zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            invalidOp <= 1'b0;
        end else begin
            invalidOp <= invalid_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases followed by random traffic,
// compared against a behavioural model written with plain integer arithmetic.
// Optional feature macro: ALU_OPCHECK_EN (also checks invalidOp).
module tb_alu;

    logic        clock;
    logic        reset;
    logic        controlBit;
    logic [4:0]  Number1;
    logic [4:0]  Number2;
    logic [5:0]  printout;
    logic        balancebit;
    logic        equalityBit;
    logic [31:0] conclusion;
`ifdef ALU_OPCHECK_EN
    logic        invalidOp;
`endif

    int testCount = 0;
    int failCount = 0;

    alu dut (
        .clock       (clock),
        .reset       (reset),
        .controlBit  (controlBit),
        .Number1     (Number1),
        .Number2     (Number2),
        .printout    (printout),
        .balancebit  (balancebit),
        .equalityBit (equalityBit),
        .conclusion  (conclusion)
`ifdef ALU_OPCHECK_EN
        ,
        .invalidOp   (invalidOp)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference result computed directly from the operation table.
    function automatic logic [31:0] modelResult(input logic ctl, input int unsigned a,
                                                input int unsigned b, input int unsigned op);
        if (!ctl) begin
            case (op)
                0: return a + b;
                1: return a - b;
                2: return a * b;
                3: return (b == 0) ? 32'hFFFF_FFFF : a / b;
                4: return (b == 0) ? a : a % b;
                5: return a + 1;
                6: return a - 1;
                default: return 32'd0;
            endcase
        end
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return (~(a & b)) & 32'd31;
            4: return (~(a | b)) & 32'd31;
            5: return (~(a ^ b)) & 32'd31;
            6: return (~a) & 32'd31;
            7: return a << b;
            8: return a >> b;
            default: return 32'd0;
        endcase
    endfunction

    // Reference for the illegal-operation marker.
    function automatic logic modelInvalid(input logic ctl, input int unsigned b,
                                          input int unsigned op);
        if (!ctl) return (op > 6) || ((op == 3 || op == 4) && b == 0);
        return (op > 8);
    endfunction

    // Count one comparison and report it if it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one operation, let one edge pass, then check every output.
    task automatic applyStimulus(input logic ctl, input logic [4:0] a,
                                 input logic [4:0] b, input logic [5:0] op);
        @(negedge clock);
        controlBit = ctl;
        Number1    = a;
        Number2    = b;
        printout   = op;
        @(posedge clock);
        #1;
        checkOutput($sformatf("result c%0d op%0d a%0d b%0d", ctl, op, a, b),
                    conclusion, modelResult(ctl, a, b, op));
        checkOutput("balancebit", 32'(balancebit), 32'(a > b));
        checkOutput("equalityBit", 32'(equalityBit), 32'(a == b));
`ifdef ALU_OPCHECK_EN
        checkOutput("invalidOp", 32'(invalidOp), 32'(modelInvalid(ctl, b, op)));
`endif
    endtask

    initial begin
        reset      = 1'b0;
        controlBit = 1'b0;
        Number1    = 5'd5;
        Number2    = 5'd4;
        printout   = 6'd1;

        // Held in reset: everything stays zero across edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checkOutput("reset conclusion", conclusion, 32'd0);
            checkOutput("reset balancebit", 32'(balancebit), 32'd0);
            checkOutput("reset equalityBit", 32'(equalityBit), 32'd0);
`ifdef ALU_OPCHECK_EN
            checkOutput("reset invalidOp", 32'(invalidOp), 32'd0);
`endif
        end

        // Release: first edge after release computes 5-4.
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("release conclusion", conclusion, 32'd1);
        checkOutput("release balancebit", 32'(balancebit), 32'd1);
        checkOutput("release equalityBit", 32'(equalityBit), 32'd0);

        // Directed arithmetic and logic cases from the operation table.
        applyStimulus(1'b0, 5'd4, 5'd5, 6'd1);
        checkOutput("sub negative", conclusion, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 5'd31, 5'd31, 6'd2);
        checkOutput("mul max", conclusion, 32'd961);
        applyStimulus(1'b0, 5'd7, 5'd0, 6'd3);
        checkOutput("div zero", conclusion, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 5'd7, 5'd0, 6'd4);
        checkOutput("mod zero", conclusion, 32'd7);
        applyStimulus(1'b0, 5'd0, 5'd3, 6'd6);
        applyStimulus(1'b1, 5'b10110, 5'b01101, 6'd0);
        checkOutput("and", conclusion, 32'd4);
        applyStimulus(1'b1, 5'b10110, 5'b01101, 6'd1);
        checkOutput("or", conclusion, 32'd31);
        applyStimulus(1'b1, 5'b10110, 5'b01101, 6'd2);
        checkOutput("xor", conclusion, 32'd27);
        applyStimulus(1'b1, 5'b10110, 5'b01101, 6'd6);
        checkOutput("not", conclusion, 32'd9);
        applyStimulus(1'b1, 5'd1, 5'd31, 6'd7);
        checkOutput("shl 31", conclusion, 32'h8000_0000);

        // Unlisted opcode, then a legal one so the marker must drop again.
        applyStimulus(1'b1, 5'd9, 5'd3, 6'd63);
        checkOutput("unlisted", conclusion, 32'd0);
        applyStimulus(1'b0, 5'd9, 5'd3, 6'd0);

        // Asynchronous reset between edges, then release.
        applyStimulus(1'b0, 5'd3, 5'd4, 6'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset conclusion", conclusion, 32'd0);
        @(posedge clock);
        #1;
        checkOutput("held reset conclusion", conclusion, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("post reset conclusion", conclusion, 32'd7);

        // Random traffic, mostly legal opcodes with occasional wild ones.
        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
            else                           op = 6'($urandom_range(0, 8));
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), op);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
